// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared states, opcodes, function selects and control bundle
package control_unit_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH_L, FETCH_H, DECODE, EXEC, HALT} state_t;
  typedef enum logic [1:0] {FS_DEC, FS_INC, FS_LOAD, FS_CLEAR} funsel_t;
  localparam logic [3:0] OP_BZ  = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef struct packed {
    logic       memRd;
    logic       irE;
    logic       irLH;
    funsel_t    irFunSel;
    logic       pcE;
    funsel_t    pcFunSel;
    logic [3:0] rfRegSel;
    funsel_t    rfFunSel;
    logic [1:0] rfO1Sel;
    logic [1:0] rfO2Sel;
    logic [3:0] aluFunSel;
    logic       muxSel;
    logic       busy;
    logic       halt;
  } ctrl_t;
  function automatic logic isAluOp(input logic [3:0] op);
    return op <= 4'hC;
  endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: controller-to-datapath bundle
interface control_unit_if;
  logic        Start;
  logic [15:0] IRout;
  logic [3:0]  Zcno;
  logic        Mem_RD;
  logic        IR_E;
  logic        IR_LH;
  logic [1:0]  IR_FunSel;
  logic        PC_E;
  logic [1:0]  PC_FunSel;
  logic [3:0]  RF_RegSel;
  logic [1:0]  RF_FunSel;
  logic [1:0]  RF_O1Sel;
  logic [1:0]  RF_O2Sel;
  logic [3:0]  ALU_FunSel;
  logic        MuxSel;
  logic        Busy;
  logic        Halt;
  modport master (
    output Start, IRout, Zcno,
    input  Mem_RD, IR_E, IR_LH, IR_FunSel, PC_E, PC_FunSel, RF_RegSel, RF_FunSel,
           RF_O1Sel, RF_O2Sel, ALU_FunSel, MuxSel, Busy, Halt
  );
  modport slave (
    input  Start, IRout, Zcno,
    output Mem_RD, IR_E, IR_LH, IR_FunSel, PC_E, PC_FunSel, RF_RegSel, RF_FunSel,
           RF_O1Sel, RF_O2Sel, ALU_FunSel, MuxSel, Busy, Halt
  );
endinterface

// File: rtl/control_unit_decoder.sv
// ctrl_decoder: Moore decode of state plus IR fields into datapath controls
module ctrl_decoder
  import control_unit_pkg::*;
(
  input  state_t      state,
  input  logic [15:6] irHi,
  input  logic        zFlag,
  output ctrl_t       ctrl
);
  logic [3:0] opcode;
  logic [3:0] dstSel;
  logic fetch, exec, aluExec, rfWrite, bzTaken;
  assign opcode  = irHi[15:12];
  assign dstSel  = ~(4'b1000 >> irHi[11:10]);
  assign fetch   = state == FETCH_L || state == FETCH_H;
  assign exec    = state == EXEC;
  assign aluExec = exec && isAluOp(opcode);
  assign rfWrite = aluExec || (exec && opcode == OP_LDI);
  assign bzTaken = exec && opcode == OP_BZ && zFlag;
  // Every field starts at its idle default; each state only overrides what it drives
  always_comb begin
    ctrl = '0;
    ctrl.memRd = fetch;
    ctrl.irE = fetch || state == CLEAR;
    ctrl.irLH = state == FETCH_H;
    ctrl.irFunSel = state == CLEAR ? FS_CLEAR : fetch ? FS_LOAD : FS_DEC;
    ctrl.pcE = fetch || state == CLEAR || bzTaken;
    ctrl.pcFunSel = state == CLEAR ? FS_CLEAR : fetch ? FS_INC : bzTaken ? FS_LOAD : FS_DEC;
    ctrl.rfRegSel = rfWrite ? dstSel : 4'b1111;
    ctrl.rfFunSel = rfWrite ? FS_LOAD : FS_DEC;
    ctrl.rfO1Sel = aluExec ? irHi[9:8] : 2'b00;
    ctrl.rfO2Sel = aluExec ? irHi[7:6] : 2'b00;
    ctrl.aluFunSel = aluExec ? opcode : 4'h0;
    ctrl.muxSel = exec && opcode == OP_LDI;
    ctrl.busy = state != IDLE && state != HALT;
    ctrl.halt = state == HALT;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer with latched zero flag
module control_unit
  import control_unit_pkg::*;
(
  input logic Clk,
  input logic Rst,
  control_unit_if.slave bus
);
  state_t state, nextState;
  logic zFlag;
  ctrl_t ctrl;
  // State register; reset lands in IDLE immediately so outputs default without a clock
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= nextState;
  // Sequencing: IDLE waits for Start, instructions loop FETCH_L..EXEC, HLT parks in HALT
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = bus.Start ? CLEAR : IDLE;
      CLEAR:   nextState = FETCH_L;
      FETCH_L: nextState = FETCH_H;
      FETCH_H: nextState = DECODE;
      DECODE:  nextState = bus.IRout[15:12] == OP_HLT ? HALT : EXEC;
      EXEC:    nextState = FETCH_L;
      default: nextState = state;
    endcase
  end
  // Zero flag captured from the ALU only by ALU-class instructions
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) zFlag <= 1'b0;
    else if (state == CLEAR) zFlag <= 1'b0;
    else if (state == EXEC && isAluOp(bus.IRout[15:12])) zFlag <= bus.Zcno[3];
  ctrl_decoder decoder (
    .state(state),
    .irHi(bus.IRout[15:6]),
    .zFlag(zFlag),
    .ctrl(ctrl)
  );
  assign bus.Mem_RD     = ctrl.memRd;
  assign bus.IR_E       = ctrl.irE;
  assign bus.IR_LH      = ctrl.irLH;
  assign bus.IR_FunSel  = ctrl.irFunSel;
  assign bus.PC_E       = ctrl.pcE;
  assign bus.PC_FunSel  = ctrl.pcFunSel;
  assign bus.RF_RegSel  = ctrl.rfRegSel;
  assign bus.RF_FunSel  = ctrl.rfFunSel;
  assign bus.RF_O1Sel   = ctrl.rfO1Sel;
  assign bus.RF_O2Sel   = ctrl.rfO2Sel;
  assign bus.ALU_FunSel = ctrl.aluFunSel;
  assign bus.MuxSel     = ctrl.muxSel;
  assign bus.Busy       = ctrl.busy;
  assign bus.Halt       = ctrl.halt;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized check of control_unit against a phase model
module tb_control_unit;
  logic Clk = 0;
  logic Rst = 0;
  control_unit_if bus();
  control_unit dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_HALT = 3;
  int nChecks = 0;
  int nFails = 0;
  bit started = 0;
  int mode = M_IDLE;
  int step = 0;
  bit zModel = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic instr(input logic [15:0] ir, input logic [3:0] zc);
    tick();
    bus.IRout = ir;
    bus.Zcno = zc;
    repeat (3) tick();
  endtask
  function automatic logic [24:0] actVec();
    return {bus.Mem_RD, bus.IR_E, bus.IR_LH, bus.IR_FunSel, bus.PC_E, bus.PC_FunSel,
            bus.RF_RegSel, bus.RF_FunSel, bus.RF_O1Sel, bus.RF_O2Sel, bus.ALU_FunSel,
            bus.MuxSel, bus.Busy, bus.Halt};
  endfunction
  function automatic logic [24:0] expVec();
    logic fetch, clr, ex, alu, ldi, bz;
    logic [3:0] op;
    logic [3:0] sel;
    logic [1:0] irFs, pcFs;
    int dst;
    op = bus.IRout[15:12];
    dst = int'(bus.IRout[11:10]);
    fetch = mode == M_RUN && step < 2;
    clr = mode == M_CLEAR;
    ex = mode == M_RUN && step == 3;
    alu = ex && op <= 4'd12;
    ldi = ex && op == 4'd14;
    bz = ex && op == 4'd13 && zModel;
    sel = 4'b1111;
    if (alu || ldi) sel[3 - dst] = 1'b0;
    irFs = clr ? 2'd3 : fetch ? 2'd2 : 2'd0;
    pcFs = clr ? 2'd3 : fetch ? 2'd1 : bz ? 2'd2 : 2'd0;
    return {fetch, fetch || clr, mode == M_RUN && step == 1, irFs, fetch || clr || bz, pcFs,
            sel, (alu || ldi) ? 2'd2 : 2'd0, alu ? bus.IRout[9:8] : 2'd0,
            alu ? bus.IRout[7:6] : 2'd0, alu ? op : 4'd0, ldi,
            mode == M_CLEAR || mode == M_RUN, mode == M_HALT};
  endfunction
  // Reference model: instruction phase counter and zero flag advanced from sampled inputs
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mode = M_IDLE;
      step = 0;
      zModel = 0;
    end else if (mode == M_IDLE) begin
      if (bus.Start) mode = M_CLEAR;
    end else if (mode == M_CLEAR) begin
      zModel = 0;
      mode = M_RUN;
      step = 0;
    end else if (mode == M_RUN) begin
      if (step == 2 && bus.IRout[15:12] == 4'hF) mode = M_HALT;
      else if (step == 3) begin
        if (bus.IRout[15:12] <= 4'd12) zModel = bus.Zcno[3];
        step = 0;
      end else step = step + 1;
    end
  end
  // Every mid-cycle, the full control vector must match the model
  always @(negedge Clk)
    if (started) chk("ctrl", 32'(actVec()), 32'(expVec()));
  initial begin
    bus.Start = 0;
    bus.IRout = 16'h0000;
    bus.Zcno = 4'h0;
    #1 Rst = 1;
    #2;
    chk("rst_regsel", bus.RF_RegSel, 4'b1111);
    chk("rst_busy", bus.Busy, 0);
    started = 1;
    tick();
    Rst = 0;
    tick();
    chk("idle_hold", bus.Busy, 0);
    bus.Start = 1;
    tick();
    bus.Start = 0;
    chk("clear_irfs", bus.IR_FunSel, 2'b11);
    chk("clear_pcfs", bus.PC_FunSel, 2'b11);
    chk("clear_busy", bus.Busy, 1);
    tick();
    chk("fetchl_memrd", bus.Mem_RD, 1);
    chk("fetchl_irlh", bus.IR_LH, 0);
    chk("fetchl_pcfs", bus.PC_FunSel, 2'b01);
    tick();
    chk("fetchh_irlh", bus.IR_LH, 1);
    #2 Rst = 1;
    #1;
    chk("async_regsel", bus.RF_RegSel, 4'b1111);
    chk("async_busy", bus.Busy, 0);
    chk("async_memrd", bus.Mem_RD, 0);
    Rst = 0;
    tick();
    chk("after_rst_idle", bus.Busy, 0);
    bus.Start = 1;
    tick();
    bus.Start = 0;
    instr(16'h4900, 4'h0);
    chk("alu_fs", bus.ALU_FunSel, 4'h4);
    chk("alu_o1", bus.RF_O1Sel, 2'b01);
    chk("alu_o2", bus.RF_O2Sel, 2'b00);
    chk("alu_regsel", bus.RF_RegSel, 4'b1101);
    chk("alu_rffs", bus.RF_FunSel, 2'b10);
    chk("alu_mux", bus.MuxSel, 0);
    instr(16'hE87F, 4'b1000);
    chk("ldi_mux", bus.MuxSel, 1);
    chk("ldi_regsel", bus.RF_RegSel, 4'b1101);
    instr(16'hD020, 4'h0);
    chk("bz_after_ldi_pce", bus.PC_E, 0);
    instr(16'h4900, 4'b1000);
    instr(16'hD020, 4'h0);
    chk("bz_taken_pce", bus.PC_E, 1);
    chk("bz_taken_pcfs", bus.PC_FunSel, 2'b10);
    instr(16'h0000, 4'h0);
    instr(16'hD020, 4'h0);
    chk("bz_not_taken_pce", bus.PC_E, 0);
    instr(16'hF000, 4'h0);
    chk("halt_flag", bus.Halt, 1);
    chk("halt_busy", bus.Busy, 0);
    bus.Start = 1;
    repeat (3) tick();
    bus.Start = 0;
    chk("halt_ignores_start", bus.Halt, 1);
    #2 Rst = 1;
    #1;
    chk("halt_rst_halt", bus.Halt, 0);
    chk("halt_rst_busy", bus.Busy, 0);
    Rst = 0;
    repeat (3000) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if (ir[15:12] == 4'hF && $urandom_range(0, 3) != 0) ir[15:12] = 4'($urandom_range(0, 14));
      bus.IRout = ir;
      bus.Start = $urandom_range(0, 3) == 0;
      bus.Zcno = 4'($urandom);
      tick();
      if ($urandom_range(0, 59) == 0) begin
        #1 Rst = 1;
        #1 Rst = 0;
      end
    end
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
